// File: rtl/period_meter.sv
// Measures period and high time of a slow asynchronous clock-like input in clk cycles,
// with a completed-period counter and a stall flag when rising edges stop arriving.
module period_meter #(
  parameter int unsigned      CNT_W   = 32,
  parameter longint unsigned  TIMEOUT = 4000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             period_valid,
  output logic             stalled,
  output logic [15:0]      period_cnt
);

  // state   | meaning
  // IDLE    | after reset; first rise only starts timing
  // MEASURE | timing a period; each rise completes a measurement
  // STALLED | no rise for TIMEOUT cycles; next rise restarts timing
  typedef enum logic [1:0] {IDLE, MEASURE, STALLED} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  state_t           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] hi_q, hi_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             stalled_q, stalled_d;
  logic [15:0]      pcnt_q, pcnt_d;

  logic             rise, fall, at_timeout;
  logic [CNT_W-1:0] cnt_inc;

  assign rise       = s2_q & ~s3_q;
  assign fall       = ~s2_q & s3_q;
  assign cnt_inc    = cnt_q + CNT_W'(1);
  assign at_timeout = (cnt_inc == TIMEOUT_C);

  always_comb begin
    state_d   = state_q;
    cnt_d     = rise ? '0 : cnt_inc;
    hi_d      = fall ? cnt_inc : hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    stalled_d = stalled_q;
    pcnt_d    = pcnt_q;
    case (state_q)
      IDLE: begin
        if (rise) begin
          state_d = MEASURE;
        end else if (at_timeout) begin
          state_d   = STALLED;
          stalled_d = 1'b1;
        end
      end
      MEASURE: begin
        // a rise coinciding with the timeout completes the measurement
        if (rise) begin
          period_d  = cnt_inc;
          high_d    = hi_q;
          valid_d   = 1'b1;
          pcnt_d    = pcnt_q + 16'd1;
          stalled_d = 1'b0;
        end else if (at_timeout) begin
          state_d   = STALLED;
          stalled_d = 1'b1;
        end
      end
      STALLED: begin
        if (rise) state_d = MEASURE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      s3_q      <= 1'b0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      stalled_q <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      s1_q      <= sig_in;
      s2_q      <= s1_q;
      s3_q      <= s2_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      stalled_q <= stalled_d;
      pcnt_q    <= pcnt_d;
    end
  end

  assign period_out   = period_q;
  assign high_out     = high_q;
  assign period_valid = valid_q;
  assign stalled      = stalled_q;
  assign period_cnt   = pcnt_q;

endmodule
